// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the 65C02 bus between the CPU and NUM_REQ secondary masters by halting (RDY),
// tri-stating (BE) and then granting one requester. Define BUS_ARBITER_ROUND_ROBIN_EN for round-robin selection.
module bus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  input  logic               mlock,
  output logic               busen,
  output logic               ready,
  output logic               cpu_owns,
  output logic [1:0]         owner,
  output logic               timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HALT    = 3'd1,
    S_BUS_OFF = 3'd2,
    S_GRANTED = 3'd3,
    S_RELEASE = 3'd4,
    S_RESUME  = 3'd5
  } state_e;

  localparam int              HW        = $clog2(MAX_HOLD) + 1;
  localparam logic [2:0]      CNT_LAST  = 3'(TURNAROUND - 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

  state_e             state_q;
  logic [2:0]         cnt_q;
  logic [HW-1:0]      hold_q;
  logic [NUM_REQ-1:0] excl_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               busen_q;
  logic               ready_q;
  logic               owns_q;
  logic               timeout_q;
  logic [1:0]         owner_q;

  logic [NUM_REQ-1:0] cand_s;
  logic               win_found_s;
  logic [1:0]         win_idx_s;
  logic               cnt_last_s;
  logic               owner_req_s;

  // Returns {found, index} of the lowest set bit.
  function automatic logic [2:0] first_set(input logic [NUM_REQ-1:0] v);
    logic [NUM_REQ-1:0] s;
    logic [2:0]         r;
    s = v;
    r = 3'b000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!r[2] && s[0]) begin
        r = {1'b1, 2'(i)};
      end
      s = s >> 1;
    end
    return r;
  endfunction

  assign cnt_last_s  = (cnt_q == CNT_LAST);
  assign owner_req_s = |(req & grant_q);
  // A timed-out master only sits out the selection made at the end of RELEASE.
  assign cand_s      = (state_q == S_RELEASE) ? (req & ~excl_q) : req;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  logic [1:0]           rr_q;
  logic [2*NUM_REQ-1:0] dbl_s;
  logic [2:0]           rot_s;
  logic [2:0]           sum_s;

  // Rotate the candidates so the search starts just past the last owner.
  always_comb begin
    dbl_s       = {cand_s, cand_s} >> ({1'b0, rr_q} + 3'd1);
    rot_s       = first_set(dbl_s[NUM_REQ-1:0]);
    sum_s       = {1'b0, rr_q} + 3'd1 + {1'b0, rot_s[1:0]};
    win_found_s = rot_s[2];
    if (sum_s >= 3'(NUM_REQ)) begin
      win_idx_s = 2'(sum_s - 3'(NUM_REQ));
    end else begin
      win_idx_s = sum_s[1:0];
    end
  end
`else
  logic [2:0] pick_s;

  always_comb begin
    pick_s      = first_set(cand_s);
    win_found_s = pick_s[2];
    win_idx_s   = pick_s[1:0];
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      hold_q    <= '0;
      excl_q    <= '0;
      grant_q   <= '0;
      busen_q   <= 1'b1;
      ready_q   <= 1'b1;
      owns_q    <= 1'b1;
      owner_q   <= 2'd0;
      timeout_q <= 1'b0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      rr_q      <= 2'd0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q  <= 3'd0;
          excl_q <= '0;
          // mlock low means an RMW is in flight; the CPU must not be stopped mid-sequence.
          if ((|req) && mlock) begin
            state_q <= S_HALT;
            ready_q <= 1'b0;
            owns_q  <= 1'b0;
          end
        end
        S_HALT: begin
          if (cnt_last_s) begin
            state_q <= S_BUS_OFF;
            busen_q <= 1'b0;
            cnt_q   <= 3'd0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_BUS_OFF, S_RELEASE: begin
          if (cnt_last_s) begin
            cnt_q <= 3'd0;
            if (win_found_s) begin
              state_q <= S_GRANTED;
              grant_q <= NUM_REQ'(1'b1) << win_idx_s;
              owner_q <= win_idx_s;
              hold_q  <= '0;
              excl_q  <= '0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
              rr_q    <= win_idx_s;
`endif
            end else begin
              state_q <= S_RESUME;
              busen_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_GRANTED: begin
          if (hold_q != {HW{1'b1}}) begin
            hold_q <= hold_q + HW'(1'b1);
          end
          if (!owner_req_s) begin
            state_q <= S_RELEASE;
            grant_q <= '0;
          end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST)) begin
            state_q   <= S_RELEASE;
            grant_q   <= '0;
            timeout_q <= 1'b1;
            excl_q    <= grant_q;
          end
        end
        S_RESUME: begin
          if (cnt_last_s) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            owns_q  <= 1'b1;
            cnt_q   <= 3'd0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 3'd0;
          grant_q <= '0;
          busen_q <= 1'b1;
          ready_q <= 1'b1;
          owns_q  <= 1'b1;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign busen    = busen_q;
  assign ready    = ready_q;
  assign cpu_owns = owns_q;
  assign owner    = owner_q;
  assign timeout  = timeout_q;

endmodule
